fetch_queue: RTL and testbench

Parametrised instruction-fetch front end for the next-generation pipelined core. It owns the fetch PC and drives a synchronous-read instruction ROM with one cycle of latency. Returned words go into a DEPTH-entry FIFO, which is drained by the decode/execute stage through a valid/ready handshake. A redirect input from execute (taken branch or jump) flushes the FIFO and any in-flight ROM word, then restarts fetch at the target. This replaces the single-register fetch with NOP injection, and adds decoupling and back-pressure.

---
 rtl/fetch_queue_if.sv | 49 ++++
 rtl/fetch_queue.sv | 121 ++++++++++++
 tb/tb_fetch_queue.sv | 412 ++++++++++++++++++++++++++++++++++++++++
 3 files changed

// File: rtl/fetch_queue_if.sv
// Handshake bundle for fetch_queue: ROM read port, decode-side valid/ready output,
// redirect request and occupancy.
interface fetch_queue_if #(
    parameter int unsigned ADDR_W = 16,
    parameter int unsigned DEPTH  = 4
);
    localparam int unsigned CNT_W = $clog2(DEPTH) + 1;

    logic [ADDR_W-1:0] rom_addr;
    logic              rom_en;
    logic [31:0]       rom_data;

    logic              out_valid;
    logic              out_ready;
    logic [31:0]       out_instr;
    logic [ADDR_W-1:0] out_pc;

    logic              redirect;
    logic [ADDR_W-1:0] redirect_pc;

    logic [CNT_W-1:0]  count;

    // master: the fetch queue itself; slave: ROM plus decode/execute side
    modport master (
        output rom_addr,
        output rom_en,
        input  rom_data,
        output out_valid,
        input  out_ready,
        output out_instr,
        output out_pc,
        input  redirect,
        input  redirect_pc,
        output count
    );

    modport slave (
        input  rom_addr,
        input  rom_en,
        output rom_data,
        input  out_valid,
        output out_ready,
        input  out_instr,
        input  out_pc,
        output redirect,
        output redirect_pc,
        input  count
    );
endinterface

// File: rtl/fetch_queue.sv
// Instruction-fetch front end: owns the fetch PC, reads a 1-cycle-latency ROM and buffers
// returned words in a DEPTH-entry FIFO drained by a valid/ready consumer; redirect flushes.
module fetch_queue #(
    parameter int unsigned          ADDR_W   = 16,
    parameter int unsigned          DEPTH    = 4,
    parameter logic [ADDR_W-1:0]    RESET_PC = '0
) (
    input  logic             clk,
    input  logic             rst_n,
    fetch_queue_if.master    bus
);
    localparam int unsigned PTR_W = $clog2(DEPTH);
    localparam int unsigned CNT_W = PTR_W + 1;
    localparam int unsigned CMP_W = PTR_W + 2;
    localparam logic [31:0] NOP   = 32'h0000_0013;

    if (DEPTH < 2 || (DEPTH & (DEPTH - 1)) != 0) begin : g_bad_depth
        $error("fetch_queue: DEPTH must be a power of 2 and at least 2");
    end
    if (RESET_PC[1:0] != 2'b00) begin : g_bad_reset_pc
        $error("fetch_queue: RESET_PC must be 4-byte aligned");
    end

    logic [ADDR_W-1:0] fpc_q, fpc_d;
    logic [PTR_W-1:0]  wr_ptr_q, wr_ptr_d;
    logic [PTR_W-1:0]  rd_ptr_q, rd_ptr_d;
    logic [CNT_W-1:0]  count_q, count_d;
    logic              inflight_q, inflight_d;
    logic [ADDR_W-1:0] inflight_pc_q, inflight_pc_d;

    logic [31:0]       instr_mem [DEPTH];
    logic [ADDR_W-1:0] pc_mem    [DEPTH];

    logic              valid;
    logic              pop;
    logic              push;
    logic              issue;
    logic [CMP_W-1:0]  occupancy;
    logic [ADDR_W-1:0] target;

    // Handshake and issue decisions
    always_comb begin
        valid     = rst_n & ~bus.redirect & (count_q != '0);
        pop       = valid & bus.out_ready;
        // Words already held or due next cycle, minus the one leaving now; never underflows
        // because a pop implies count_q >= 1.
        occupancy = CMP_W'(count_q) + CMP_W'(inflight_q) - CMP_W'(pop);
        issue     = rst_n & ~bus.redirect & (occupancy < CMP_W'(DEPTH));
        push      = rst_n & ~bus.redirect & inflight_q;
        target    = bus.redirect_pc & ~ADDR_W'(3);
    end

    // Next-state
    always_comb begin
        fpc_d         = fpc_q;
        wr_ptr_d      = wr_ptr_q;
        rd_ptr_d      = rd_ptr_q;
        count_d       = count_q;
        inflight_d    = 1'b0;
        inflight_pc_d = inflight_pc_q;

        if (bus.redirect) begin
            fpc_d    = target;
            wr_ptr_d = '0;
            rd_ptr_d = '0;
            count_d  = '0;
        end else begin
            if (issue) begin
                fpc_d         = fpc_q + ADDR_W'(4);
                inflight_d    = 1'b1;
                inflight_pc_d = fpc_q;
            end
            if (push) begin
                wr_ptr_d = wr_ptr_q + PTR_W'(1);
            end
            if (pop) begin
                rd_ptr_d = rd_ptr_q + PTR_W'(1);
            end
            count_d = count_q + CNT_W'(push) - CNT_W'(pop);
        end
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            fpc_q         <= RESET_PC;
            wr_ptr_q      <= '0;
            rd_ptr_q      <= '0;
            count_q       <= '0;
            inflight_q    <= 1'b0;
            inflight_pc_q <= '0;
        end else begin
            fpc_q         <= fpc_d;
            wr_ptr_q      <= wr_ptr_d;
            rd_ptr_q      <= rd_ptr_d;
            count_q       <= count_d;
            inflight_q    <= inflight_d;
            inflight_pc_q <= inflight_pc_d;
        end
    end

    // Storage needs no reset: entries are only read when count marks them valid
    always_ff @(posedge clk) begin
        if (push) begin
            instr_mem[wr_ptr_q] <= bus.rom_data;
            pc_mem[wr_ptr_q]    <= inflight_pc_q;
        end
    end

    assign bus.rom_addr  = fpc_q;
    assign bus.rom_en    = issue;
    assign bus.out_valid = valid;
    assign bus.out_instr = valid ? instr_mem[rd_ptr_q] : NOP;
    assign bus.out_pc    = valid ? pc_mem[rd_ptr_q] : '0;
    assign bus.count     = count_q;

    // The issue rule reserves a slot for every in-flight word
    a_no_overflow: assert property (@(posedge clk) disable iff (!rst_n)
        push |-> (count_q != CNT_W'(DEPTH)));
    a_count_range: assert property (@(posedge clk) disable iff (!rst_n)
        count_q <= CNT_W'(DEPTH));
endmodule

// File: tb/tb_fetch_queue.sv
// Bench for fetch_queue: directed scenarios plus a randomised run against a
// transaction-level model of the expected PC stream.
module tb_fetch_queue;
    localparam int unsigned ADDR_W     = 16;
    localparam int unsigned DEPTH      = 4;
    localparam logic [15:0] RESET_PC   = 16'h0000;
    localparam int unsigned W_ADDR_W   = 8;
    localparam logic [7:0]  W_RESET_PC = 8'hF8;
    localparam logic [31:0] NOP        = 32'h0000_0013;

    logic clk = 1'b0;
    logic rst_n;
    logic rst_n_w;
    int   n_cmp = 0;
    int   n_bad = 0;

    always #5 clk = ~clk;

    fetch_queue_if #(.ADDR_W(ADDR_W),   .DEPTH(DEPTH)) bus ();
    fetch_queue_if #(.ADDR_W(W_ADDR_W), .DEPTH(DEPTH)) wbus ();

    fetch_queue #(.ADDR_W(ADDR_W), .DEPTH(DEPTH), .RESET_PC(RESET_PC)) dut (
        .clk   (clk),
        .rst_n (rst_n),
        .bus   (bus.master)
    );

    fetch_queue #(.ADDR_W(W_ADDR_W), .DEPTH(DEPTH), .RESET_PC(W_RESET_PC)) dut_w (
        .clk   (clk),
        .rst_n (rst_n_w),
        .bus   (wbus.master)
    );

    // ROMs: word = 0x100 + byte address, one cycle of read latency
    always @(posedge clk) begin
        if (bus.rom_en) bus.rom_data <= 32'h100 + 32'(bus.rom_addr);
        if (wbus.rom_en) wbus.rom_data <= 32'h100 + 32'(wbus.rom_addr);
    end

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    task automatic next_cycle();
        @(posedge clk);
        #2;
    endtask

    // Leaves the bench in cycle 0 (first cycle with rst_n=1), inputs not yet settled
    task automatic do_reset(input logic ready);
        rst_n           = 1'b0;
        bus.redirect    = 1'b0;
        bus.redirect_pc = '0;
        bus.out_ready   = ready;
        repeat (2) next_cycle();
        rst_n = 1'b1;
    endtask

    task automatic test_reset();
        rst_n           = 1'b0;
        bus.out_ready   = 1'b1;
        bus.redirect    = 1'b1;
        bus.redirect_pc = 16'h0080;
        repeat (2) next_cycle();
        #1;
        n_cmp++;
        if (bus.rom_en !== 1'b0 || bus.out_valid !== 1'b0) begin
            n_bad++;
            $display("FAIL reset_ctrl: rom_en=%b out_valid=%b, required 0 0",
                     bus.rom_en, bus.out_valid);
        end
        n_cmp++;
        if (bus.out_instr !== NOP || bus.out_pc !== 16'h0) begin
            n_bad++;
            $display("FAIL reset_data: instr=%h pc=%h, required %h 0000",
                     bus.out_instr, bus.out_pc, NOP);
        end
        n_cmp++;
        if (bus.count !== 3'd0) begin
            n_bad++;
            $display("FAIL reset_count: count=%0d, required 0", bus.count);
        end
        rst_n        = 1'b1;
        bus.redirect = 1'b0;
        #1;
        n_cmp++;
        if (bus.rom_en !== 1'b1 || bus.rom_addr !== RESET_PC) begin
            n_bad++;
            $display("FAIL cold_c0: rom_en=%b addr=%h, required 1 %h",
                     bus.rom_en, bus.rom_addr, RESET_PC);
        end
        next_cycle();
        #1;
        n_cmp++;
        if (bus.out_valid !== 1'b0 || bus.rom_addr !== RESET_PC + 16'd4) begin
            n_bad++;
            $display("FAIL cold_c1: out_valid=%b addr=%h, required 0 %h",
                     bus.out_valid, bus.rom_addr, RESET_PC + 16'd4);
        end
        next_cycle();
        #1;
        n_cmp++;
        if (bus.out_valid !== 1'b1 || bus.out_pc !== RESET_PC
            || bus.out_instr !== 32'h100 + 32'(RESET_PC)) begin
            n_bad++;
            $display("FAIL cold_c2: valid=%b pc=%h instr=%h, required 1 %h %h",
                     bus.out_valid, bus.out_pc, bus.out_instr, RESET_PC,
                     32'h100 + 32'(RESET_PC));
        end
    endtask

    task automatic test_stream();
        logic [15:0] exp_pc;
        exp_pc = RESET_PC;
        do_reset(1'b1);
        for (int c = 0; c < 20; c++) begin
            #1;
            if (c >= 2) begin
                n_cmp++;
                if (bus.out_valid !== 1'b1 || bus.out_pc !== exp_pc
                    || bus.out_instr !== 32'h100 + 32'(exp_pc)) begin
                    n_bad++;
                    $display("FAIL stream c%0d: valid=%b pc=%h instr=%h, required 1 %h %h",
                             c, bus.out_valid, bus.out_pc, bus.out_instr, exp_pc,
                             32'h100 + 32'(exp_pc));
                end
                exp_pc = exp_pc + 16'd4;
            end
            n_cmp++;
            if (bus.count > 3'd2) begin
                n_bad++;
                $display("FAIL stream_count c%0d: count=%0d, required <= 2", c, bus.count);
            end
            next_cycle();
        end
    endtask

    task automatic test_back_pressure();
        logic [15:0] exp_pc;
        do_reset(1'b0);
        for (int c = 0; c < 10; c++) begin
            #1;
            if (c >= 5) begin
                n_cmp++;
                if (bus.count !== 3'(DEPTH) || bus.rom_en !== 1'b0) begin
                    n_bad++;
                    $display("FAIL bp_full c%0d: count=%0d rom_en=%b, required %0d 0",
                             c, bus.count, bus.rom_en, DEPTH);
                end
            end
            next_cycle();
        end
        bus.out_ready = 1'b1;
        #1;
        n_cmp++;
        if (bus.rom_en !== 1'b1) begin
            n_bad++;
            $display("FAIL bp_pop_issue: rom_en=%b, required 1", bus.rom_en);
        end
        exp_pc = RESET_PC;
        for (int c = 0; c < 8; c++) begin
            if (c > 0) begin
                next_cycle();
                #1;
            end
            n_cmp++;
            if (bus.out_valid !== 1'b1 || bus.out_pc !== exp_pc) begin
                n_bad++;
                $display("FAIL bp_drain %0d: valid=%b pc=%h, required 1 %h",
                         c, bus.out_valid, bus.out_pc, exp_pc);
            end
            exp_pc = exp_pc + 16'd4;
        end
        next_cycle();
    endtask

    task automatic test_redirect();
        logic [15:0] exp_pc;
        bit          seen;
        do_reset(1'b0);
        repeat (4) next_cycle();
        #1;
        n_cmp++;
        if (bus.count !== 3'd3) begin
            n_bad++;
            $display("FAIL redir_pre: count=%0d, required 3", bus.count);
        end
        bus.redirect    = 1'b1;
        bus.redirect_pc = 16'h0042;
        #1;
        n_cmp++;
        if (bus.out_valid !== 1'b0 || bus.rom_en !== 1'b0) begin
            n_bad++;
            $display("FAIL redir_t: valid=%b rom_en=%b, required 0 0",
                     bus.out_valid, bus.rom_en);
        end
        next_cycle();
        bus.redirect  = 1'b0;
        bus.out_ready = 1'b1;
        #1;
        n_cmp++;
        if (bus.out_valid !== 1'b0 || bus.rom_en !== 1'b1 || bus.rom_addr !== 16'h0040) begin
            n_bad++;
            $display("FAIL redir_t1: valid=%b rom_en=%b addr=%h, required 0 1 0040",
                     bus.out_valid, bus.rom_en, bus.rom_addr);
        end
        exp_pc = 16'h0040;
        seen   = 1'b0;
        for (int c = 0; c < 10; c++) begin
            next_cycle();
            #1;
            if (bus.out_valid) begin
                seen = 1'b1;
                n_cmp++;
                if (bus.out_pc !== exp_pc || bus.out_instr !== 32'h100 + 32'(exp_pc)) begin
                    n_bad++;
                    $display("FAIL redir_seq: pc=%h instr=%h, required %h %h",
                             bus.out_pc, bus.out_instr, exp_pc, 32'h100 + 32'(exp_pc));
                end
                exp_pc = exp_pc + 16'd4;
            end
        end
        n_cmp++;
        if (!seen) begin
            n_bad++;
            $display("FAIL redir_timeout: no valid output after redirect, required one");
        end
    endtask

    task automatic test_back_to_back();
        bit seen;
        do_reset(1'b1);
        repeat (5) next_cycle();
        bus.redirect    = 1'b1;
        bus.redirect_pc = 16'h0200;
        next_cycle();
        bus.redirect_pc = 16'h0301;
        #1;
        n_cmp++;
        if (bus.rom_en !== 1'b0 || bus.out_valid !== 1'b0) begin
            n_bad++;
            $display("FAIL b2b_t1: rom_en=%b valid=%b, required 0 0", bus.rom_en, bus.out_valid);
        end
        next_cycle();
        bus.redirect = 1'b0;
        #1;
        n_cmp++;
        if (bus.rom_en !== 1'b1 || bus.rom_addr !== 16'h0300 || bus.out_valid !== 1'b0) begin
            n_bad++;
            $display("FAIL b2b_t2: rom_en=%b addr=%h valid=%b, required 1 0300 0",
                     bus.rom_en, bus.rom_addr, bus.out_valid);
        end
        seen = 1'b0;
        for (int c = 0; c < 6 && !seen; c++) begin
            next_cycle();
            #1;
            if (bus.out_valid) begin
                seen = 1'b1;
                n_cmp++;
                if (bus.out_pc !== 16'h0300) begin
                    n_bad++;
                    $display("FAIL b2b_first: pc=%h, required 0300", bus.out_pc);
                end
            end
        end
        n_cmp++;
        if (!seen) begin
            n_bad++;
            $display("FAIL b2b_timeout: no valid output, required one");
        end
    endtask

    task automatic test_reset_midstream();
        bit seen;
        do_reset(1'b1);
        repeat (6) next_cycle();
        rst_n           = 1'b0;
        bus.redirect    = 1'b1;
        bus.redirect_pc = 16'h0080;
        #1;
        n_cmp++;
        if (bus.rom_en !== 1'b0 || bus.out_valid !== 1'b0 || bus.out_pc !== 16'h0
            || bus.out_instr !== NOP) begin
            n_bad++;
            $display("FAIL rstmid_in: rom_en=%b valid=%b pc=%h instr=%h, required 0 0 0000 %h",
                     bus.rom_en, bus.out_valid, bus.out_pc, bus.out_instr, NOP);
        end
        next_cycle();
        rst_n        = 1'b1;
        bus.redirect = 1'b0;
        #1;
        n_cmp++;
        if (bus.count !== 3'd0 || bus.out_valid !== 1'b0 || bus.out_instr !== NOP
            || bus.rom_addr !== RESET_PC) begin
            n_bad++;
            $display("FAIL rstmid_after: count=%0d valid=%b instr=%h addr=%h, required 0 0 %h %h",
                     bus.count, bus.out_valid, bus.out_instr, bus.rom_addr, NOP, RESET_PC);
        end
        seen = 1'b0;
        for (int c = 0; c < 6 && !seen; c++) begin
            next_cycle();
            #1;
            if (bus.out_valid) begin
                seen = 1'b1;
                n_cmp++;
                if (bus.out_pc !== RESET_PC) begin
                    n_bad++;
                    $display("FAIL rstmid_first: pc=%h, required %h", bus.out_pc, RESET_PC);
                end
            end
        end
        n_cmp++;
        if (!seen) begin
            n_bad++;
            $display("FAIL rstmid_timeout: no valid output, required one");
        end
    endtask

    task automatic test_wrap();
        logic [7:0] exp_pc;
        rst_n_w          = 1'b0;
        wbus.out_ready   = 1'b1;
        wbus.redirect    = 1'b0;
        wbus.redirect_pc = '0;
        repeat (2) next_cycle();
        rst_n_w = 1'b1;
        exp_pc  = W_RESET_PC;
        for (int c = 0; c < 18; c++) begin
            #1;
            if (c >= 2) begin
                n_cmp++;
                if (wbus.out_valid !== 1'b1 || wbus.out_pc !== exp_pc
                    || wbus.out_instr !== 32'h100 + 32'(exp_pc)) begin
                    n_bad++;
                    $display("FAIL wrap c%0d: valid=%b pc=%h instr=%h, required 1 %h %h",
                             c, wbus.out_valid, wbus.out_pc, wbus.out_instr, exp_pc,
                             32'h100 + 32'(exp_pc));
                end
                exp_pc = exp_pc + 8'd4;
            end
            next_cycle();
        end
        rst_n_w = 1'b0;
    endtask

    // Model: the popped stream is the arithmetic sequence from the last restart point
    task automatic test_random();
        logic [15:0] exp_pc;
        int          pops;
        do_reset(1'b1);
        exp_pc = RESET_PC;
        pops   = 0;
        for (int c = 0; c < 600; c++) begin
            bus.out_ready   = ($urandom_range(0, 3) != 0);
            bus.redirect    = ($urandom_range(0, 19) == 0);
            bus.redirect_pc = 16'($urandom);
            #1;
            n_cmp++;
            if (bus.count > 3'(DEPTH)) begin
                n_bad++;
                $display("FAIL rand_count c%0d: count=%0d, required <= %0d", c, bus.count, DEPTH);
            end
            if (bus.redirect) begin
                n_cmp++;
                if (bus.out_valid !== 1'b0) begin
                    n_bad++;
                    $display("FAIL rand_redir_valid c%0d: valid=%b, required 0", c, bus.out_valid);
                end
                exp_pc = bus.redirect_pc & 16'hFFFC;
            end else if (bus.out_valid && bus.out_ready) begin
                n_cmp++;
                if (bus.out_pc !== exp_pc || bus.out_instr !== 32'h100 + 32'(exp_pc)) begin
                    n_bad++;
                    $display("FAIL rand_pop c%0d: pc=%h instr=%h, required %h %h",
                             c, bus.out_pc, bus.out_instr, exp_pc, 32'h100 + 32'(exp_pc));
                end
                exp_pc = exp_pc + 16'd4;
                pops++;
            end
            next_cycle();
        end
        bus.redirect = 1'b0;
        n_cmp++;
        if (pops < 200) begin
            n_bad++;
            $display("FAIL rand_progress: pops=%0d, required >= 200", pops);
        end
    endtask

    initial begin
        rst_n            = 1'b0;
        rst_n_w          = 1'b0;
        bus.out_ready    = 1'b0;
        bus.redirect     = 1'b0;
        bus.redirect_pc  = '0;
        wbus.out_ready   = 1'b0;
        wbus.redirect    = 1'b0;
        wbus.redirect_pc = '0;
        test_reset();
        test_stream();
        test_back_pressure();
        test_redirect();
        test_back_to_back();
        test_reset_midstream();
        test_wrap();
        test_random();
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end
endmodule
